// File: rtl/dff_arb_pkg.sv
// Shared command and FSM state encodings for dff_bank_arbiter.
package dff_arb_pkg;

  localparam logic [1:0] CMD_HOLD  = 2'b00;
  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_SET   = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_RELEASE = 2'b10
  } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational requester picker: first asserted req searching upward from ptr, wrapping at NREQ.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] k_s;

  // scan all positions from ptr; the first hit is kept
  always_comb begin
    valid = 1'b0;
    idx   = {IW{1'b0}};
    k_s   = {IW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      k_s = IW'((int'(ptr) + i) % NREQ);
      if (!valid && req[k_s]) begin
        valid = 1'b1;
        idx   = k_s;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Arbitrates NREQ requesters onto one shared WIDTH-bit flip-flop register.
// Define DFF_ARB_ROUND_ROBIN_EN for round-robin picking; otherwise lowest index wins.
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       req_cmd,
  input  logic [WIDTH*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic [WIDTH-1:0]        q,
  output logic [WIDTH-1:0]        qbar
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [IW-1:0]     g_q, g_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [IW-1:0]     ptr_s;
  logic              pick_valid_s;
  logic [IW-1:0]     pick_idx_s;
  logic              req_g_s;
  logic [1:0]        cmd_s;
  logic [WIDTH-1:0]  data_s;
  logic              commit_s;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req   (req),
    .ptr   (ptr_s),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

`ifdef DFF_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // an aborted grant leaves the search start where it was
  always_comb begin
    if (commit_s) begin
      if (g_q == IW'(NREQ - 1)) begin
        ptr_d = {IW{1'b0}};
      end else begin
        ptr_d = g_q + IW'(1'b1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= {IW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_s = ptr_q;
`else
  assign ptr_s = {IW{1'b0}};
`endif

  always_comb begin
    req_g_s = 1'b0;
    cmd_s   = CMD_HOLD;
    data_s  = {WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (g_q == IW'(i)) begin
        req_g_s = req[i];
        cmd_s   = req_cmd[2*i +: 2];
        data_s  = req_data[WIDTH*i +: WIDTH];
      end else begin
        req_g_s = req_g_s;
      end
    end
  end

  // gnt_d/busy_d describe the state being entered so the outputs are registered
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    gnt_d    = {NREQ{1'b0}};
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_d = ST_GRANT;
          g_d     = pick_idx_s;
          for (int i = 0; i < NREQ; i++) begin
            gnt_d[i] = (pick_idx_s == IW'(i));
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (req_g_s) begin
          commit_s = 1'b1;
          state_d  = ST_RELEASE;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (!req_g_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      g_q     <= {IW{1'b0}};
      gnt_q   <= {NREQ{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    if (commit_s) begin
      case (cmd_s)
        CMD_HOLD:  q_d = q_q;
        CMD_LOAD:  q_d = data_s;
        CMD_SET:   q_d = {WIDTH{1'b1}};
        CMD_CLEAR: q_d = {WIDTH{1'b0}};
        default:   q_d = q_q;
      endcase
    end else begin
      q_d = q_q;
    end
  end

  // the shared D flip-flop bank
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign qbar = ~q_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scoreboard bench for dff_bank_arbiter: driver predicts each grant and resulting q, monitor checks.
module tb_dff_bank_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     req_cmd;
  logic [WIDTH*NREQ-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qbar;

  dff_bank_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_cmd  (req_cmd),
    .req_data (req_data),
    .gnt      (gnt),
    .busy     (busy),
    .q        (q),
    .qbar     (qbar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0]  g;
    logic [WIDTH-1:0] q;
  } exp_t;

  exp_t             sb[$];
  int               n_checks;
  int               n_fail;
  logic             mon_en;
  logic [WIDTH-1:0] m_q;
  int               m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: search order from the last committed winner + 1 (round-robin) or from 0.
  function automatic int model_pick(input logic [NREQ-1:0] m);
    int start;
`ifdef DFF_ARB_ROUND_ROBIN_EN
    start = m_ptr;
`else
    start = 0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (m[(start + i) % NREQ]) return (start + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] model_apply(input logic [WIDTH-1:0] cur,
                                                  input logic [1:0] c,
                                                  input logic [WIDTH-1:0] d);
    case (c)
      2'b00:   return cur;
      2'b01:   return d;
      2'b10:   return {WIDTH{1'b1}};
      default: return {WIDTH{1'b0}};
    endcase
  endfunction

  // mode 0: commit, 1: drop request during grant, 2: reset during grant
  task automatic txn(input logic [NREQ-1:0] mask, input logic [2*NREQ-1:0] cmds,
                     input logic [WIDTH*NREQ-1:0] datas, input int mode);
    int   w;
    int   t;
    exp_t e;
    @(negedge clk);
    req      = mask;
    req_cmd  = cmds;
    req_data = datas;
    w = model_pick(mask);
    e.g = '0;
    e.g[w] = 1'b1;
    if (mode == 0) begin
      m_q   = model_apply(m_q, cmds[2*w +: 2], datas[WIDTH*w +: WIDTH]);
      m_ptr = (w + 1) % NREQ;
    end else if (mode == 2) begin
      m_q   = '0;
      m_ptr = 0;
    end
    e.q = m_q;
    sb.push_back(e);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (gnt == '0 && t < 8);
    check("gnt_seen", 32'(gnt != '0), 32'd1);
    if (gnt == '0) begin
      req = '0;
      return;
    end
    check("busy_in_grant", 32'(busy), 32'd1);
    if (mode == 1) begin
      req = '0;
      @(negedge clk);
      check("busy_after_abort", 32'(busy), 32'd0);
    end else if (mode == 2) begin
      reset = 1'b1;
      @(negedge clk);
      check("busy_after_reset", 32'(busy), 32'd0);
      check("gnt_after_reset", 32'(gnt), 32'd0);
      reset = 1'b0;
      req   = '0;
    end else begin
      @(negedge clk);
      check("busy_in_release", 32'(busy), 32'd1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("busy_held", 32'(busy), 32'd1);
      end
      req[w] = 1'b0;
      @(negedge clk);
      check("busy_after_release", 32'(busy), 32'd0);
      req = '0;
    end
  endtask

  // Monitor: every gnt pulse is matched to the next scoreboard entry; q is checked one cycle later.
  initial begin
    logic [NREQ-1:0]  prev_gnt;
    logic             pend;
    logic [WIDTH-1:0] pq;
    logic [WIDTH-1:0] nq;
    exp_t             e;
    prev_gnt = '0;
    pend     = 1'b0;
    pq       = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        nq = ~q;
        check("qbar_inv", 32'(qbar), 32'(nq));
        if (pend) begin
          check("q_after_cmd", 32'(q), 32'(pq));
          pend = 1'b0;
        end
        if (gnt != '0) begin
          check("gnt_gap", 32'(prev_gnt), 32'd0);
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL gnt_unexpected: got %b required no grant", gnt);
          end else begin
            e = sb.pop_front();
            check("gnt_onehot", 32'(gnt), 32'(e.g));
            pq   = e.q;
            pend = 1'b1;
          end
        end
        prev_gnt = gnt;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    logic [2*NREQ-1:0]     c;
    logic [WIDTH*NREQ-1:0] d;
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    m_q      = '0;
    m_ptr    = 0;
    reset    = 1'b1;
    req      = NREQ'($urandom());
    req_cmd  = (2*NREQ)'($urandom());
    req_data = (WIDTH*NREQ)'($urandom());

    repeat (3) begin
      @(negedge clk);
      mon_en = 1'b1;
      check("reset_q", 32'(q), 32'h00);
      check("reset_qbar", 32'(qbar), 32'hFF);
      check("reset_gnt", 32'(gnt), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      req = NREQ'($urandom());
    end
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
    check("post_reset_q", 32'(q), 32'h00);
    check("post_reset_gnt", 32'(gnt), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);

    // reset during GRANT of a LOAD 0x3C
    c = (2*NREQ)'($urandom()); c[1:0] = 2'b01;
    d = (WIDTH*NREQ)'($urandom()); d[7:0] = 8'h3C;
    txn(4'b0001, c, d, 2);

    // single load from requester 1
    c = (2*NREQ)'($urandom()); c[3:2] = 2'b01;
    d = (WIDTH*NREQ)'($urandom()); d[15:8] = 8'hA5;
    txn(4'b0010, c, d, 0);

    // SET then CLEAR from requester 2
    c = (2*NREQ)'($urandom()); c[5:4] = 2'b10;
    txn(4'b0100, c, (WIDTH*NREQ)'($urandom()), 0);
    c[5:4] = 2'b11;
    txn(4'b0100, c, (WIDTH*NREQ)'($urandom()), 0);

    // abort from requester 3, then a committed grant to 3 again
    c = (2*NREQ)'($urandom()); c[7:6] = 2'b01;
    d = (WIDTH*NREQ)'($urandom()); d[31:24] = 8'hC3;
    txn(4'b1000, c, d, 1);
    txn(4'b1000, c, d, 0);

    // all requesters contending
    repeat (5) begin
      txn(4'b1111, (2*NREQ)'($urandom()), (WIDTH*NREQ)'($urandom()), 0);
    end

    // random traffic with occasional aborts
    repeat (40) begin
      txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), (2*NREQ)'($urandom()),
          (WIDTH*NREQ)'($urandom()), ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Shares one WIDTH-bit storage register, built from D flip-flops, between NREQ requesters. Each requester raises a request with a command (hold, load, set, clear). The arbiter grants one requester at a time, applies its command to the register for exactly one cycle, and then waits for that requester to release. The block sits between the register-file users and the flip-flop bank and provides the register's q/qbar outputs directly.

## Interface
- WIDTH, 8, register width in bits (>=1)
- NREQ, 4, number of requesters (2..8)
- clk  input  1  clock, rising-edge active
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk
- req  input  NREQ  per-requester request level
- req_cmd  input  2*NREQ  flattened 2-bit command; requester i uses bits [2i+1:2i]
- req_data  input  WIDTH*NREQ  flattened load data; requester i uses bits [WIDTH*i +: WIDTH]
- gnt  output  NREQ  one-hot grant, high for exactly one cycle per transaction
- busy  output  1  high whenever the state is not IDLE
- q  output  WIDTH  register contents
- qbar  output  WIDTH  bitwise complement of q, always

## Operation
- Command encoding:
  - 2'b00 HOLD: granted, register unchanged.
  - 2'b01 LOAD: q <= data.
  - 2'b10 SET: q <= all ones.
  - 2'b11 CLEAR: q <= all zeros.
- FSM has three states: IDLE, GRANT, RELEASE.
- IDLE:
  - If any req bit is high, latch the picked index g and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: gnt[g] is high for the whole state. On the next edge:
  - If req[g] is still high, commit: sample req_cmd/req_data of g, update q, set ptr <= (g+1) mod NREQ, go to RELEASE.
  - If req[g] has dropped, abort: no write, ptr unchanged, go to IDLE.
- RELEASE: gnt is all zeros. Go to IDLE on the first edge where req[g] is low; otherwise stay.
- Picking:
  - Round-robin (see Configuration): the search starts at ptr and wraps modulo NREQ; the first high req bit wins.
  - Requests arriving while the state is GRANT or RELEASE wait until IDLE.
- Reset values: state IDLE, q=0, qbar=all ones, gnt=0, busy=0, ptr=0, g=0.
- Reset asserted in any state abandons the transaction at that edge. No write occurs even if the state was GRANT.
- qbar is derived combinationally from q. q and qbar must never be equal in any bit.

## Timing
- Edge E0 (IDLE, req high) -> during E0..E1 the state is GRANT and gnt[g]=1.
- q updates at edge E1, i.e. 2 edges after req is first sampled.
- Minimum transaction length: 3 edges when req[g] drops in the cycle after gnt (IDLE -> GRANT -> RELEASE -> IDLE).
- Back-to-back service: the next grant can start 1 cycle after returning to IDLE. Grant cycles are never adjacent.
- busy rises the cycle after E0 and falls the cycle after leaving RELEASE.
- gnt is registered: it is glitch-free and fully decoded from the state and g registers.

## Configuration
- DFF_ARB_ROUND_ROBIN_EN:
  - Defined: round-robin picking from ptr as described above.
  - Undefined: fixed priority (lowest asserted index wins), and the ptr register is removed.
- In both builds all other timing and behaviour are identical.

## Structure
- Package dff_arb_pkg holds:
  - localparams CMD_HOLD, CMD_LOAD, CMD_SET, CMD_CLEAR;
  - the state encoding ST_IDLE, ST_GRANT, ST_RELEASE (2 bits).
- Sub-module rr_picker: combinational; inputs req and ptr; outputs valid and the index of the picked requester. In the fixed-priority build ptr is tied to 0.
- The register itself stays inside the top module as a single always block.

## Test plan
- Reset: hold reset for 3 cycles with random req -> q=0x00, qbar=0xFF, gnt=0, busy=0 throughout, and on the first edge after release.
- Single load: req[1]=1, cmd=01, data=0xA5 -> gnt=4'b0010 for one cycle; q=0xA5 and qbar=0x5A two edges after req.
- SET then CLEAR: requester 2 issues SET (q=0xFF), releases, then issues CLEAR -> q=0x00. gnt[2] pulses twice, with at least one idle cycle between pulses.
- Fairness: req=4'b1111 held continuously, each requester releasing one cycle after its grant.
  - Round-robin build: grant order is 0,1,2,3,0.
  - Fixed-priority build: requester 0 wins every time it re-asserts.
- Abort: req[3] drops during GRANT -> no change to q, next state IDLE, ptr unchanged. The next grant with req=4'b1000 again goes to 3.
- Reset mid-transaction: assert reset in GRANT with cmd=LOAD 0x3C -> q stays 0 and the state returns to IDLE.
